// File: rtl/writeback_pkg.sv
// Shared encodings for the write-back stage: mux selects, load sizes,
// halt FSM states and the bit layout of the packed control word.
package writeback_pkg;

  typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MEM = 2'd1, WB_LINK = 2'd2, WB_RSVD = 2'd3} wb_sel_e;
  typedef enum logic [1:0] {DST_RT = 2'd0, DST_RD = 2'd1, DST_LINK = 2'd2, DST_NONE = 2'd3} dest_sel_e;
  typedef enum logic [1:0] {LD_WORD = 2'd0, LD_HALF = 2'd1, LD_BYTE = 2'd2, LD_RSVD = 2'd3} ld_size_e;
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_DRAIN = 2'd1, ST_HALTED = 2'd2} wb_state_e;

  localparam int CTL_VALID     = 0;
  localparam int CTL_REG_WRITE = 1;
  localparam int CTL_LD_UNS    = 2;
  localparam int CTL_W         = 3;

  localparam int DRAIN_CYCLES  = 2;

endpackage

// File: rtl/writeback_unit_load_align.sv
// Big-endian sub-word load aligner: picks the addressed byte/half from the
// memory word and sign- or zero-extends it. Misaligned halves round down.
module load_align
  import writeback_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] mem_data,
  input  logic [1:0]        offset,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  output logic [DATA_W-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // Byte 0 is the most significant byte of the word.
    case (offset)
      2'd0:    byte_sel = mem_data[31:24];
      2'd1:    byte_sel = mem_data[23:16];
      2'd2:    byte_sel = mem_data[15:8];
      default: byte_sel = mem_data[7:0];
    endcase
    half_sel = offset[1] ? mem_data[15:0] : mem_data[31:16];

    case (ld_size_e'(size))
      LD_HALF: data = {{(DATA_W-16){~is_unsigned & half_sel[15]}}, half_sel};
      LD_BYTE: data = {{(DATA_W-8){~is_unsigned & byte_sel[7]}}, byte_sel};
      default: data = mem_data;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Final pipeline stage: selects write-back data/destination, drives the
// register-file write port (also the forwarding bus), counts retirements, halts.
module writeback_unit
  import writeback_pkg::*;
#(
  parameter int              DATA_W     = 32,
  parameter int              REG_ADDR_W = 5,
  parameter int              LINK_REG   = 31,
  parameter int              CNT_W      = 32,
  parameter logic [DATA_W-1:0] HALT_INSN = 32'h0000_000D
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_insn,
  input  logic [DATA_W-1:0]     in_pc,
  input  logic [DATA_W-1:0]     in_alu_result,
  input  logic [DATA_W-1:0]     in_mem_data,
  input  logic [1:0]            in_wb_sel,
  input  logic [1:0]            in_dest_sel,
  input  logic                  in_reg_write,
  input  logic [1:0]            in_ld_size,
  input  logic                  in_ld_unsigned,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic [CNT_W-1:0]      retired,
  output logic                  halted
);

  wb_state_e             state_q, state_d;
  logic [1:0]            drain_q, drain_d;
  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]     rf_wdata_q, rf_wdata_d;
  logic [CNT_W-1:0]      retired_q, retired_d;

  logic [CTL_W-1:0]      ctl;
  logic [REG_ADDR_W-1:0] dest_addr;
  logic [DATA_W-1:0]     load_data, wdata_n;
  logic                  accept, halt_hit, do_write;

  assign ctl = {in_ld_unsigned, in_reg_write, in_valid};

  load_align #(.DATA_W(DATA_W)) u_align (
    .mem_data    (in_mem_data),
    .offset      (in_alu_result[1:0]),
    .size        (in_ld_size),
    .is_unsigned (ctl[CTL_LD_UNS]),
    .data        (load_data)
  );

  always_comb begin
    // Instruction bit numbering is MSB-first: rt = [11:15], rd = [16:20].
    case (dest_sel_e'(in_dest_sel))
      DST_RT:   dest_addr = in_insn[16 +: REG_ADDR_W];
      DST_RD:   dest_addr = in_insn[11 +: REG_ADDR_W];
      DST_LINK: dest_addr = REG_ADDR_W'(LINK_REG);
      default:  dest_addr = '0;
    endcase
    case (wb_sel_e'(in_wb_sel))
      WB_MEM:  wdata_n = load_data;
      WB_LINK: wdata_n = in_pc + DATA_W'(8);
      default: wdata_n = in_alu_result;
    endcase
  end

  assign accept   = ctl[CTL_VALID] & ~stall & (state_q != ST_HALTED);
  assign halt_hit = accept & (state_q == ST_RUN) & (in_insn == HALT_INSN);
  assign do_write = accept & ctl[CTL_REG_WRITE] & (dest_sel_e'(in_dest_sel) != DST_NONE)
                  & (dest_addr != '0) & ~halt_hit;

  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    retired_d  = retired_q;

    // A stalled edge keeps address/data but never re-issues the write.
    if (!stall && state_q != ST_HALTED) begin
      rf_we_d    = do_write;
      rf_waddr_d = do_write ? dest_addr : '0;
      rf_wdata_d = wdata_n;
    end
    if (accept) retired_d = retired_q + CNT_W'(1);

    case (state_q)
      ST_RUN: if (halt_hit) begin
        state_d = ST_DRAIN;
        drain_d = '0;
      end
      ST_DRAIN: begin
        if (drain_q == 2'(DRAIN_CYCLES - 1)) state_d = ST_HALTED;
        else                                  drain_d = drain_q + 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RUN;
      drain_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      retired_q  <= retired_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign retired  = retired_q;
  assign halted   = (state_q == ST_HALTED);

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: vector table, random traffic against
// a field-level reference model, and directed stall/halt/reset sequences.
module tb_writeback_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall, in_valid, in_reg_write, in_ld_unsigned;
  logic [31:0] in_insn, in_pc, in_alu_result, in_mem_data;
  logic [1:0]  in_wb_sel, in_dest_sel, in_ld_size;
  logic        rf_we, halted;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, retired;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        valid;
    logic [31:0] insn, pc, alu, mem;
    logic [1:0]  wb, dest;
    logic        rw;
    logic [1:0]  sz;
    logic        uns;
  } in_t;

  typedef struct {
    in_t         i;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    bit          chk_addr;
  } vec_t;

  writeback_unit dut (
    .clock(clock), .reset(reset), .stall(stall), .in_valid(in_valid),
    .in_insn(in_insn), .in_pc(in_pc), .in_alu_result(in_alu_result),
    .in_mem_data(in_mem_data), .in_wb_sel(in_wb_sel), .in_dest_sel(in_dest_sel),
    .in_reg_write(in_reg_write), .in_ld_size(in_ld_size),
    .in_ld_unsigned(in_ld_unsigned), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .retired(retired), .halted(halted)
  );

  always #5 clock = ~clock;

  localparam logic [31:0] BRK = 32'h0000_000D;

  function automatic logic [31:0] r_insn(input logic [4:0] rt, input logic [4:0] rd);
    return {6'd0, 5'd1, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic in_t mk(input logic v, input logic [4:0] rt, input logic [4:0] rd,
                             input logic [31:0] pc, input logic [31:0] alu,
                             input logic [31:0] mem, input logic [1:0] wb,
                             input logic [1:0] dest, input logic rw,
                             input logic [1:0] sz, input logic uns);
    in_t t;
    t.valid = v; t.insn = r_insn(rt, rd); t.pc = pc; t.alu = alu; t.mem = mem;
    t.wb = wb; t.dest = dest; t.rw = rw; t.sz = sz; t.uns = uns;
    return t;
  endfunction

  // Reference: arithmetic on the instruction fields, independent of any mux structure.
  function automatic void ref_model(input in_t v, output logic we, output logic [4:0] addr,
                                    output logic [31:0] data);
    int unsigned off, b, h;
    logic [4:0] tgt;
    off = v.alu % 4;
    if (v.dest == 2'd0)      tgt = v.insn[20:16];
    else if (v.dest == 2'd1) tgt = v.insn[15:11];
    else                     tgt = 5'd31;
    if (v.wb == 2'd1) begin
      if (v.sz == 2'd2) begin
        b = (v.mem >> (8 * (3 - off))) % 256;
        data = (v.uns || b < 128) ? b : b + 32'hFFFF_FF00;
      end else if (v.sz == 2'd1) begin
        h = (v.mem >> (16 * (1 - off / 2))) % 65536;
        data = (v.uns || h < 32768) ? h : h + 32'hFFFF_0000;
      end else data = v.mem;
    end else if (v.wb == 2'd2) data = v.pc + 32'd8;
    else data = v.alu;
    we = v.valid && v.rw && v.dest != 2'd3 && tgt != 5'd0;
    addr = we ? tgt : 5'd0;
  endfunction

  task automatic drive(input in_t v, input logic st);
    stall = st; in_valid = v.valid; in_insn = v.insn; in_pc = v.pc;
    in_alu_result = v.alu; in_mem_data = v.mem; in_wb_sel = v.wb;
    in_dest_sel = v.dest; in_reg_write = v.rw; in_ld_size = v.sz;
    in_ld_unsigned = v.uns;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  vec_t        tbl[$];
  in_t         idle, v, brk;
  logic        e_we;
  logic [4:0]  e_addr;
  logic [31:0] e_data, e_ret, last_addr, last_data;
  bit          have_last;

  initial begin
    idle = mk(1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 2'd0, 2'd3, 1'b0, 2'd0, 1'b0);
    drive(idle, 1'b0);
    reset = 1'b1;
    tick(); tick();
    chk("reset_we", {31'd0, rf_we}, 32'd0);
    chk("reset_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("reset_wdata", rf_wdata, 32'd0);
    chk("reset_retired", retired, 32'd0);
    chk("reset_halted", {31'd0, halted}, 32'd0);
    reset = 1'b0;

    // {inputs, we, addr, data, check-addr-when-no-write}
    tbl.push_back('{mk(1, 5'd2, 5'd5, 32'h0, 32'h0000_0007, 32'h0, 2'd0, 2'd1, 1, 2'd0, 0), 1, 5'd5, 32'h0000_0007, 0});
    tbl.push_back('{mk(1, 5'd8, 5'd0, 32'h0, 32'h0000_1003, 32'h1122_33F0, 2'd1, 2'd0, 1, 2'd2, 0), 1, 5'd8, 32'hFFFF_FFF0, 0});
    tbl.push_back('{mk(1, 5'd8, 5'd0, 32'h0, 32'h0000_1003, 32'h1122_33F0, 2'd1, 2'd0, 1, 2'd2, 1), 1, 5'd8, 32'h0000_00F0, 0});
    tbl.push_back('{mk(1, 5'd9, 5'd0, 32'h0, 32'h0000_1002, 32'h1122_33F0, 2'd1, 2'd0, 1, 2'd1, 0), 1, 5'd9, 32'h0000_33F0, 0});
    tbl.push_back('{mk(1, 5'd9, 5'd0, 32'h0, 32'h0000_1002, 32'h1122_B3F0, 2'd1, 2'd0, 1, 2'd1, 0), 1, 5'd9, 32'hFFFF_B3F0, 0});
    tbl.push_back('{mk(1, 5'd9, 5'd0, 32'h0, 32'h0000_1002, 32'h1122_B3F0, 2'd1, 2'd0, 1, 2'd1, 1), 1, 5'd9, 32'h0000_B3F0, 0});
    tbl.push_back('{mk(1, 5'd10, 5'd0, 32'h0, 32'h0000_1001, 32'h8122_33F0, 2'd1, 2'd0, 1, 2'd1, 0), 1, 5'd10, 32'hFFFF_8122, 0});
    tbl.push_back('{mk(1, 5'd11, 5'd0, 32'h0, 32'h0000_1000, 32'h8000_0000, 2'd1, 2'd0, 1, 2'd2, 0), 1, 5'd11, 32'hFFFF_FF80, 0});
    tbl.push_back('{mk(1, 5'd12, 5'd0, 32'h0, 32'h0000_1001, 32'hDEAD_BEEF, 2'd1, 2'd0, 1, 2'd0, 0), 1, 5'd12, 32'hDEAD_BEEF, 0});
    tbl.push_back('{mk(1, 5'd0, 5'd0, 32'h8002_0010, 32'h5, 32'h0, 2'd2, 2'd2, 1, 2'd0, 0), 1, 5'd31, 32'h8002_0018, 0});
    tbl.push_back('{mk(1, 5'd0, 5'd0, 32'hFFFF_FFFC, 32'h5, 32'h0, 2'd2, 2'd2, 1, 2'd0, 0), 1, 5'd31, 32'h0000_0004, 0});
    tbl.push_back('{mk(1, 5'd0, 5'd7, 32'h0, 32'h1234_5678, 32'h0, 2'd0, 2'd0, 1, 2'd0, 0), 0, 5'd0, 32'h0, 1});
    tbl.push_back('{mk(1, 5'd6, 5'd7, 32'h0, 32'h1234_5678, 32'h0, 2'd0, 2'd3, 1, 2'd0, 0), 0, 5'd0, 32'h0, 0});
    tbl.push_back('{mk(1, 5'd6, 5'd7, 32'h0, 32'h1234_5678, 32'h0, 2'd0, 2'd1, 0, 2'd0, 0), 0, 5'd0, 32'h0, 0});
    tbl.push_back('{mk(0, 5'd6, 5'd7, 32'h0, 32'h1234_5678, 32'h0, 2'd0, 2'd1, 1, 2'd0, 0), 0, 5'd0, 32'h0, 0});
    tbl.push_back('{mk(1, 5'd6, 5'd7, 32'h0, 32'hCAFE_0001, 32'h0, 2'd3, 2'd1, 1, 2'd0, 0), 1, 5'd7, 32'hCAFE_0001, 0});

    e_ret = 32'd0;
    for (int n = 0; n < tbl.size(); n++) begin
      drive(tbl[n].i, 1'b0);
      tick();
      if (tbl[n].i.valid) e_ret++;
      chk($sformatf("vec%0d_we", n), {31'd0, rf_we}, {31'd0, tbl[n].we});
      if (tbl[n].we || tbl[n].chk_addr) chk($sformatf("vec%0d_waddr", n), {27'd0, rf_waddr}, {27'd0, tbl[n].addr});
      if (tbl[n].we) chk($sformatf("vec%0d_wdata", n), rf_wdata, tbl[n].data);
      chk($sformatf("vec%0d_retired", n), retired, e_ret);
    end

    // Random traffic with random stalls against the reference model.
    have_last = 0;
    for (int n = 0; n < 300; n++) begin
      v.valid = ($urandom_range(0, 7) != 0);
      v.insn  = $urandom();
      if (v.insn == BRK) v.insn = 32'h0000_0020;
      v.pc = $urandom(); v.alu = $urandom(); v.mem = $urandom();
      v.wb = 2'($urandom_range(0, 3)); v.dest = 2'($urandom_range(0, 3));
      v.rw = ($urandom_range(0, 4) != 0); v.sz = 2'($urandom_range(0, 2));
      v.uns = 1'($urandom_range(0, 1));
      stall = 1'b0;
      drive(v, ($urandom_range(0, 3) == 0));
      tick();
      if (stall) begin
        chk("rand_stall_we", {31'd0, rf_we}, 32'd0);
        if (have_last) begin
          chk("rand_stall_waddr", {27'd0, rf_waddr}, last_addr);
          chk("rand_stall_wdata", rf_wdata, last_data);
        end
      end else begin
        ref_model(v, e_we, e_addr, e_data);
        if (v.valid) e_ret++;
        chk("rand_we", {31'd0, rf_we}, {31'd0, e_we});
        have_last = e_we;
        if (e_we) begin
          chk("rand_waddr", {27'd0, rf_waddr}, {27'd0, e_addr});
          chk("rand_wdata", rf_wdata, e_data);
          last_addr = {27'd0, e_addr};
          last_data = e_data;
        end
      end
      chk("rand_retired", retired, e_ret);
    end

    // Stall held for 3 cycles over a valid write: one pulse, after release.
    drive(idle, 1'b0);
    tick();
    e_ret = retired;
    v = mk(1, 5'd0, 5'd14, 32'h0, 32'h0000_ABCD, 32'h0, 2'd0, 2'd1, 1, 2'd0, 0);
    for (int c = 0; c < 3; c++) begin
      drive(v, 1'b1);
      tick();
      chk("stall_hold_we", {31'd0, rf_we}, 32'd0);
      chk("stall_hold_retired", retired, e_ret);
    end
    drive(v, 1'b0);
    tick();
    chk("stall_release_we", {31'd0, rf_we}, 32'd1);
    chk("stall_release_waddr", {27'd0, rf_waddr}, 32'd14);
    chk("stall_release_wdata", rf_wdata, 32'h0000_ABCD);
    chk("stall_release_retired", retired, e_ret + 32'd1);
    drive(idle, 1'b0);
    tick();
    chk("stall_after_we", {31'd0, rf_we}, 32'd0);
    chk("stall_after_retired", retired, e_ret + 32'd1);

    // Two adds then BREAK: halted two cycles after the BREAK edge, retired=3.
    do_reset();
    drive(mk(1, 5'd0, 5'd3, 32'h0, 32'h11, 32'h0, 2'd0, 2'd1, 1, 2'd0, 0), 1'b0);
    tick();
    chk("halt_add1_we", {31'd0, rf_we}, 32'd1);
    chk("halt_add1_waddr", {27'd0, rf_waddr}, 32'd3);
    drive(mk(1, 5'd0, 5'd4, 32'h0, 32'h22, 32'h0, 2'd0, 2'd1, 1, 2'd0, 0), 1'b0);
    tick();
    chk("halt_add2_we", {31'd0, rf_we}, 32'd1);
    chk("halt_add2_wdata", rf_wdata, 32'h22);
    brk = mk(1, 5'd0, 5'd0, 32'h0, 32'h33, 32'h0, 2'd0, 2'd1, 1, 2'd0, 0);
    brk.insn = BRK;
    drive(brk, 1'b0);
    tick();
    chk("halt_brk_we", {31'd0, rf_we}, 32'd0);
    chk("halt_brk_retired", retired, 32'd3);
    chk("halt_brk_halted", {31'd0, halted}, 32'd0);
    drive(idle, 1'b0);
    tick();
    chk("halt_drain_halted", {31'd0, halted}, 32'd0);
    tick();
    chk("halt_done_halted", {31'd0, halted}, 32'd1);
    drive(mk(1, 5'd0, 5'd6, 32'h0, 32'h44, 32'h0, 2'd0, 2'd1, 1, 2'd0, 0), 1'b0);
    tick(); tick();
    chk("halted_ignore_we", {31'd0, rf_we}, 32'd0);
    chk("halted_ignore_retired", retired, 32'd3);
    chk("halted_sticky", {31'd0, halted}, 32'd1);

    // Reset asserted mid-write drops the write immediately.
    do_reset();
    drive(mk(1, 5'd0, 5'd9, 32'h0, 32'h55, 32'h0, 2'd0, 2'd1, 1, 2'd0, 0), 1'b0);
    tick();
    chk("rst_write_pre_we", {31'd0, rf_we}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_write_we", {31'd0, rf_we}, 32'd0);
    chk("rst_write_wdata", rf_wdata, 32'd0);
    chk("rst_write_retired", retired, 32'd0);
    reset = 1'b0;

    // Reset in DRAIN: outputs clear at once and the FSM returns to RUN.
    drive(brk, 1'b0);
    tick();
    chk("rst_drain_pre_retired", retired, 32'd1);
    drive(idle, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("rst_drain_we", {31'd0, rf_we}, 32'd0);
    chk("rst_drain_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("rst_drain_wdata", rf_wdata, 32'd0);
    chk("rst_drain_retired", retired, 32'd0);
    chk("rst_drain_halted", {31'd0, halted}, 32'd0);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    chk("rst_drain_not_halted", {31'd0, halted}, 32'd0);
    drive(mk(1, 5'd0, 5'd13, 32'h0, 32'h66, 32'h0, 2'd0, 2'd1, 1, 2'd0, 0), 1'b0);
    tick();
    chk("rst_drain_run_we", {31'd0, rf_we}, 32'd1);
    chk("rst_drain_run_wdata", rf_wdata, 32'h66);
    chk("rst_drain_run_retired", retired, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
